// File: rtl/minv_flag_reader_if.sv
// rtl/minv_flag_reader_if.sv - request/response bundle between the minv consumer and the flag reader
interface minv_flag_reader_if #(
    parameter int WIDTH = 256,
    parameter int GEN_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_bank;
    logic [GEN_W-1:0] rsp_gen;
    logic             rsp_stale;

    modport master (
        output req_valid, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_bank, rsp_gen, rsp_stale
    );

    modport slave (
        input  req_valid, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_bank, rsp_gen, rsp_stale
    );
endinterface

// File: rtl/minv_flag_reader.sv
// rtl/minv_flag_reader.sv - coherent minv read from regx1/regx2 with stale tracking across flag writes
module minv_flag_reader #(
    parameter int WIDTH = 256,
    parameter int GEN_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 minv_flag,
    input  logic                 minv_flag_we,
    input  logic [WIDTH-1:0]     regx1_q,
    input  logic [WIDTH-1:0]     regx2_q,
    output logic                 minv_rd_busy,
    minv_flag_reader_if.slave    rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             capture;
    logic [GEN_W-1:0] gen_cnt;
    logic [WIDTH-1:0] data_q;
    logic             bank_q;
    logic [GEN_W-1:0] gen_q;
    logic             stale_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A request landing on a flag write is deferred one edge so the capture
    // sees the settled flag instead of racing the register update.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd.req_valid) begin
                    capture   = !minv_flag_we;
                    state_nxt = minv_flag_we ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                capture   = 1'b1;
                state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rd.rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_cnt <= '0;
            data_q  <= '0;
            bank_q  <= 1'b0;
            gen_q   <= '0;
            stale_q <= 1'b0;
        end else begin
            if (minv_flag_we) begin
                gen_cnt <= gen_cnt + GEN_W'(1);
            end
            if (capture) begin
                data_q  <= minv_flag ? regx2_q : regx1_q;
                bank_q  <= minv_flag;
                gen_q   <= gen_cnt;
                // only reachable with a write pending in WAIT; IDLE captures require no write
                stale_q <= minv_flag_we;
            end else if (state == S_RESP) begin
                if (rd.rsp_ready) begin
                    stale_q <= 1'b0;
                end else if (minv_flag_we) begin
                    stale_q <= 1'b1;
                end
            end
        end
    end

    assign rd.req_ready  = (state == S_IDLE) && rst_n;
    assign rd.rsp_valid  = (state == S_RESP);
    assign rd.rsp_data   = data_q;
    assign rd.rsp_bank   = bank_q;
    assign rd.rsp_gen    = gen_q;
    assign rd.rsp_stale  = stale_q;
    assign minv_rd_busy  = (state == S_WAIT);

endmodule

// File: tb/tb_minv_flag_reader.sv
// tb/tb_minv_flag_reader.sv - scoreboard bench for minv_flag_reader with randomized flag-write traffic
module tb_minv_flag_reader;

    localparam int WIDTH = 256;
    localparam int GEN_W = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             bank;
        logic [GEN_W-1:0] gen;
        logic             stale;
    } rsp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             minv_flag = 1'b0;
    logic             minv_flag_we = 1'b0;
    logic             flag_next = 1'b0;
    logic [WIDTH-1:0] regx1_q = '0;
    logic [WIDTH-1:0] regx2_q = '0;
    logic             minv_rd_busy;

    int   n_cmp = 0;
    int   n_err = 0;
    int   m_gen = 0;
    rsp_t sb[$];

    minv_flag_reader_if #(.WIDTH(WIDTH), .GEN_W(GEN_W)) bus ();

    minv_flag_reader #(.WIDTH(WIDTH), .GEN_W(GEN_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .minv_flag    (minv_flag),
        .minv_flag_we (minv_flag_we),
        .regx1_q      (regx1_q),
        .regx2_q      (regx2_q),
        .minv_rd_busy (minv_rd_busy),
        .rd           (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // one clock; the flag register and generation count follow any write on that edge
    task automatic tick();
        @(posedge clk);
        #1;
        if (minv_flag_we) begin
            minv_flag = flag_next;
            m_gen     = (m_gen + 1) % (1 << GEN_W);
        end
        minv_flag_we = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.req_ready) check("req_ready_timeout", 0, 1);
    endtask

    // a: write on the accept edge; w: write on the WAIT edge; wpat: writes during the hold cycles
    task automatic txn(input bit a, input bit w, input int hold, input logic [15:0] wpat,
                       input logic [WIDTH-1:0] x1, input logic [WIDTH-1:0] x2);
        rsp_t        e;
        logic [15:0] msk;
        msk = (16'(1) << hold) - 16'(1);
        wait_ready();
        regx1_q          = x1;
        regx2_q          = x2;
        bus.req_valid    = 1'b1;
        bus.rsp_ready    = 1'b0;
        minv_flag_we     = a;
        flag_next        = ($urandom % 2) != 0;
        if (!a) begin
            e.data  = minv_flag ? x2 : x1;
            e.bank  = minv_flag;
            e.gen   = GEN_W'(m_gen);
            e.stale = |(wpat & msk);
            sb.push_back(e);
        end
        tick();
        bus.req_valid = 1'b0;
        if (a) begin
            check("wait_busy", minv_rd_busy, 1);
            check("wait_no_valid", bus.rsp_valid, 0);
            regx1_q      = rnd_word();
            regx2_q      = rnd_word();
            if (x1 == x2) begin
                regx1_q = x1;
                regx2_q = x2;
            end
            minv_flag_we = w;
            flag_next    = ($urandom % 2) != 0;
            e.data  = minv_flag ? regx2_q : regx1_q;
            e.bank  = minv_flag;
            e.gen   = GEN_W'(m_gen);
            e.stale = w | (|(wpat & msk));
            sb.push_back(e);
            tick();
        end
        check("rsp_valid_latency", bus.rsp_valid, 1);
        check("busy_off_in_resp", minv_rd_busy, 0);
        for (int i = 0; i < hold; i++) begin
            minv_flag_we = wpat[i];
            flag_next    = ($urandom % 2) != 0;
            regx1_q      = rnd_word();
            regx2_q      = rnd_word();
            tick();
            check("held_valid", bus.rsp_valid, 1);
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("req_ready_after_hs", bus.req_ready, 1);
    endtask

    task automatic flag_writes(input int n);
        for (int i = 0; i < n; i++) begin
            minv_flag_we = 1'b1;
            flag_next    = ($urandom % 2) != 0;
            tick();
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", 1, 0);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_data", bus.rsp_data, e.data);
                check("rsp_bank", bus.rsp_bank, e.bank);
                check("rsp_gen", bus.rsp_gen, e.gen);
                check("rsp_stale", bus.rsp_stale, e.stale);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        #12;
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_rsp_gen", bus.rsp_gen, 0);
        check("rst_busy", minv_rd_busy, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_req_ready", bus.req_ready, 1);

        // basic read from regx1, then held response from regx2
        minv_flag = 1'b0;
        txn(0, 0, 0, 16'h0, WIDTH'(32'h11), WIDTH'(32'h0));
        minv_flag = 1'b1;
        txn(0, 0, 5, 16'h0, WIDTH'(32'h0), WIDTH'(32'h22));
        // request on a flag write 0->1
        minv_flag = 1'b0;
        tick();
        wait_ready();
        regx2_q       = WIDTH'(32'h33);
        bus.req_valid = 1'b1;
        minv_flag_we  = 1'b1;
        flag_next     = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("t3_busy", minv_rd_busy, 1);
        sb.push_back('{data: WIDTH'(32'h33), bank: 1'b1, gen: GEN_W'(m_gen), stale: 1'b0});
        tick();
        check("t3_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        // stale pulse while in RESP, then a clean follow-up
        txn(0, 0, 3, 16'b010, rnd_word(), rnd_word());
        txn(0, 0, 0, 16'h0, rnd_word(), rnd_word());
        // generation wrap
        flag_writes(16);
        txn(0, 0, 1, 16'h0, rnd_word(), rnd_word());
        // write on both the accept and the WAIT edge
        txn(1, 1, 2, 16'h0, rnd_word(), rnd_word());

        // reset while a response is pending
        wait_ready();
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        check("t6_valid_before", bus.rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async_drop", bus.rsp_valid, 0);
        check("t6_req_ready_in_rst", bus.req_ready, 0);
        check("t6_stale_rst", bus.rsp_stale, 0);
        tick();
        rst_n = 1'b1;
        m_gen = 0;
        tick();
        check("t6_req_ready_after", bus.req_ready, 1);
        txn(0, 0, 0, 16'h0, rnd_word(), rnd_word());

        for (int k = 0; k < 40; k++) begin
            txn(($urandom % 2) != 0, ($urandom % 3) == 0, int'($urandom_range(0, 6)),
                16'($urandom) & 16'($urandom), rnd_word(), rnd_word());
            if (($urandom % 4) == 0) flag_writes(int'($urandom_range(1, 5)));
        end

        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
